mm_round_ctrl: RTL
==================

Name: mm_round_ctrl

Overview:
Round sequencer for the memory-matrix game. It requests a fresh 8-cell board from the pseudo-random board generator and shows the pattern for a fixed time, then hides it. It then takes the player's cell guesses one at a time, tracking found cells, score, lives and level. It sits between the board generator/datapath and the display/input front end, and owns every game-state transition.

Parameters:
SHOW_CYCLES, 16, clock cycles the target pattern stays visible per round (range 1 to 2^24-1)
LIVES_INIT, 3, lives at game start (range 1..3)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low; clock clk
start  input  1  level: begin game from IDLE or restart from OVER
rand_board  input  8  current pseudo-random board value from generator
guess_valid  input  1  one-cycle strobe: guess_idx holds a player guess
guess_idx  input  3  cell index guessed (0..7)
ld_board  output  1  request/enable generator to advance; high only in LOAD
display  output  8  LED pattern to show
found  output  8  cells correctly guessed this round
score  output  8  total correct guesses this game, saturating at 255
lives  output  2  remaining lives
level  output  3  rounds completed, saturating at 7
busy  output  1  high in LOAD, SHOW, PLAY, WIN
game_over  output  1  high in OVER

Behaviour:
- States: IDLE, LOAD, SHOW, PLAY, WIN, OVER. All registers update on posedge clk.
- Reset (reset=0): state=IDLE; target=0, found=0, display=0, score=0, lives=LIVES_INIT, level=0, show counter=0. This overrides any state, including mid-round.
- IDLE: display=0. If start=1, go to LOAD next cycle.
- LOAD: ld_board=1.
  - If rand_board!=0: target<=rand_board, found<=0, counter<=0, go to SHOW.
  - If rand_board==0: stay in LOAD (generator keeps advancing).
- SHOW: display=target. Counter increments each cycle. When counter==SHOW_CYCLES-1, go to PLAY. Time in SHOW is exactly SHOW_CYCLES cycles. Guesses are ignored.
- PLAY: display=found. On guess_valid, let b = target[guess_idx]:
  - b=1 and found bit clear: set found bit; score+1 (saturating).
  - b=1 and found bit already set: no change (a repeat is neither a hit nor a miss).
  - b=0: lives-1. If lives was 1, lives becomes 0 and the next state is OVER.
  - If the hit completes found==target, go to WIN.
  - guess_valid=0: hold state.
- WIN: one cycle, display=target. level+1 (saturating at 7), then go to LOAD. Score and lives carry over.
- OVER: display=target (reveal the answer), game_over=1. If start=1: score<=0, lives<=LIVES_INIT, level<=0, go to LOAD.
- Output timing: all outputs are registered or decoded from registered state only; no combinational path from input to output.
- found, score, lives and level are visible one cycle after the accepted guess.
- start is ignored in LOAD, SHOW, PLAY and WIN. guess_valid is ignored outside PLAY.
- The target is captured once per round. rand_board changing during SHOW or PLAY has no effect.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release with start=0 for 10 cycles -> state stays IDLE, display=0, lives=3, score=0, ld_board=0.
- Load and show: pulse start; rand_board=8'hA5 -> exactly 1 cycle of ld_board, then display=8'hA5 for 16 cycles, then display=8'h00 (PLAY).
- Zero board skip: rand_board=0 for 3 cycles, then 8'h81 -> ld_board high 4 cycles, target=8'h81.
- Full round win: target 8'h81, guesses 0 then 7 -> found=8'h01 then 8'h81; score=2; WIN for 1 cycle; level=1; ld_board reasserted on the next cycle.
- Repeat and miss: target 8'h81, guesses 0,0,3 -> score=1 (repeat ignored), lives=2, found=8'h01, still in PLAY.
- Game over and restart: with lives=3, three misses -> lives=0, game_over=1, display=target. Assert start -> score=0, lives=3, level=0, ld_board=1 the next cycle. Separately, assert reset=0 mid-SHOW -> IDLE on the next edge, all outputs at reset values.

Source files
------------

// File: rtl/mm_round_ctrl.sv
// Round sequencer for the memory-matrix game. It fetches a non-zero board from
// the generator, flashes it for SHOW_CYCLES cycles, then scores player guesses
// against it while tracking found cells, score, lives and level.
module mm_round_ctrl #(
  parameter int SHOW_CYCLES = 16,
  parameter int LIVES_INIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rand_board,
  input  logic       guess_valid,
  input  logic [2:0] guess_idx,
  output logic       ld_board,
  output logic [7:0] display,
  output logic [7:0] found,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] level,
  output logic       busy,
  output logic       game_over
);

  localparam logic [23:0] SHOW_LAST = 24'(SHOW_CYCLES - 1);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHOW,
    S_PLAY,
    S_WIN,
    S_OVER
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  target;
  logic [23:0] show_cnt;

  logic [7:0]  guess_mask;
  logic [7:0]  found_hit;
  logic        tgt_bit;
  logic        fnd_bit;
  logic        is_new_hit;
  logic        is_miss;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  assign guess_mask = 8'b1 << guess_idx;
  assign found_hit  = found | guess_mask;
  assign tgt_bit    = target[guess_idx];
  assign fnd_bit    = found[guess_idx];
  assign is_new_hit = guess_valid && tgt_bit && !fnd_bit;
  assign is_miss    = guess_valid && !tgt_bit;

  // State register; an active-low reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state selection and outputs decoded purely from registered state.
  always_comb begin
    state_nxt = state;
    ld_board  = 1'b0;
    busy      = 1'b0;
    game_over = 1'b0;
    display   = 8'h00;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        ld_board = 1'b1;
        busy     = 1'b1;
        if (rand_board != 8'h00) state_nxt = S_SHOW;
      end
      S_SHOW: begin
        busy    = 1'b1;
        display = target;
        if (show_cnt == SHOW_LAST) state_nxt = S_PLAY;
      end
      S_PLAY: begin
        busy    = 1'b1;
        display = found;
        if (is_miss && lives == 2'd1)                   state_nxt = S_OVER;
        else if (is_new_hit && found_hit == target)     state_nxt = S_WIN;
      end
      S_WIN: begin
        busy      = 1'b1;
        display   = target;
        state_nxt = S_LOAD;
      end
      S_OVER: begin
        game_over = 1'b1;
        display   = target;
        if (start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Round and game bookkeeping: board capture, show timer, guess scoring.
  always_ff @(posedge clk) begin
    if (!reset) begin
      target   <= 8'h00;
      found    <= 8'h00;
      score    <= 8'h00;
      lives    <= LIVES_RST;
      level    <= 3'd0;
      show_cnt <= 24'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (rand_board != 8'h00) begin
            target   <= rand_board;
            found    <= 8'h00;
            show_cnt <= 24'd0;
          end
        end
        S_SHOW: show_cnt <= show_cnt + 24'd1;
        S_PLAY: begin
          if (is_new_hit) begin
            found <= found_hit;
            score <= sat_inc8(score);
          end else if (is_miss && lives != 2'd0) begin
            lives <= lives - 2'd1;
          end
        end
        S_WIN: level <= sat_inc3(level);
        S_OVER: begin
          if (start) begin
            score <= 8'h00;
            lives <= LIVES_RST;
            level <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
